// File: rtl/register_file_wb.sv
// RV32I integer register file on the writeback interface: commits on the rising edge and serves two zero-latency decode reads with optional same-cycle bypass.
// No backpressure: a write is accepted on every edge it is presented. Also carries debug read, commit counter and last-commit capture.
module register_file_wb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteW,
    input  logic [AW-1:0]   RD_W,
    input  logic [XLEN-1:0] ResultW,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data,
    output logic [31:0]     wb_count,
    output logic [AW-1:0]   last_rd,
    output logic [XLEN-1:0] last_data
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [31:0]     r_wb_count;
    logic [AW-1:0]   r_last_rd;
    logic [XLEN-1:0] r_last_data;

    logic w_commit;
    logic w_byp1;
    logic w_byp2;

    // Writes to x0 are dropped entirely, so bookkeeping only tracks real commits.
    assign w_commit = RegWriteW && (RD_W != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_wb_count  <= '0;
            r_last_rd   <= '0;
            r_last_data <= '0;
        end else if (w_commit) begin
            r_regs[RD_W] <= ResultW;
            r_wb_count   <= r_wb_count + 32'd1;
            r_last_rd    <= RD_W;
            r_last_data  <= ResultW;
        end
    end

    assign w_byp1 = (BYPASS != 0) && RegWriteW && (RD_W == A1);
    assign w_byp2 = (BYPASS != 0) && RegWriteW && (RD_W == A2);

    always_comb begin
        RD1 = r_regs[A1];
        if (A1 == '0) begin
            RD1 = '0;
        end else if (w_byp1) begin
            RD1 = ResultW;
        end
    end

    always_comb begin
        RD2 = r_regs[A2];
        if (A2 == '0) begin
            RD2 = '0;
        end else if (w_byp2) begin
            RD2 = ResultW;
        end
    end

    // Debug port shows committed state only.
    always_comb begin
        dbg_data = r_regs[dbg_addr];
        if (dbg_addr == '0) begin
            dbg_data = '0;
        end
    end

    assign wb_count  = r_wb_count;
    assign last_rd   = r_last_rd;
    assign last_data = r_last_data;

endmodule

// File: tb/tb_register_file_wb.sv
// Directed bench for register_file_wb: one bypassing and one non-bypassing instance share the same stimulus.
module tb_register_file_wb;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RD_W;
    logic [31:0] ResultW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  dbg_addr;

    logic [31:0] rd1_b, rd2_b, dbg_b, cnt_b, ldat_b;
    logic [4:0]  lrd_b;
    logic [31:0] rd1_n, rd2_n, dbg_n, cnt_n, ldat_n;
    logic [4:0]  lrd_n;

    int n_cmp = 0;
    int n_err = 0;

    register_file_wb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1)) u_dut_byp (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW),
        .A1(A1), .A2(A2), .RD1(rd1_b), .RD2(rd2_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b),
        .wb_count(cnt_b), .last_rd(lrd_b), .last_data(ldat_b)
    );

    register_file_wb #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(0)) u_dut_nob (
        .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW),
        .A1(A1), .A2(A2), .RD1(rd1_n), .RD2(rd2_n), .dbg_addr(dbg_addr), .dbg_data(dbg_n),
        .wb_count(cnt_n), .last_rd(lrd_n), .last_data(ldat_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        RegWriteW = 1'b0;
        RD_W      = '0;
        ResultW   = '0;
        A1        = '0;
        A2        = '0;
        dbg_addr  = '0;
        #2;
        chk("rst_cnt",   cnt_b, 32'd0);
        chk("rst_lrd",   {27'd0, lrd_b}, 32'd0);
        chk("rst_ldat",  ldat_b, 32'd0);
        #10;
        rst = 1'b0;

        // x5 = 0x1234, then a mid-run asynchronous reset
        RegWriteW = 1'b1; RD_W = 5'd5; ResultW = 32'h0000_1234;
        tick();
        RegWriteW = 1'b0; A1 = 5'd5;
        #1;
        chk("x5_written",   rd1_b, 32'h0000_1234);
        chk("x5_cnt",       cnt_b, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rd1",  rd1_b, 32'd0);
        chk("async_rst_cnt",  cnt_b, 32'd0);
        chk("async_rst_lrd",  {27'd0, lrd_b}, 32'd0);
        chk("async_rst_ldat", ldat_b, 32'd0);
        rst = 1'b0;

        // basic commit to x3
        RegWriteW = 1'b1; RD_W = 5'd3; ResultW = 32'hDEAD_BEEF;
        tick();
        RegWriteW = 1'b0; A2 = 5'd3; dbg_addr = 5'd3;
        #1;
        chk("x3_rd2_byp",  rd2_b, 32'hDEAD_BEEF);
        chk("x3_rd2_nob",  rd2_n, 32'hDEAD_BEEF);
        chk("x3_dbg",      dbg_b, 32'hDEAD_BEEF);
        chk("x3_cnt",      cnt_b, 32'd1);
        chk("x3_lrd",      {27'd0, lrd_b}, 32'd3);
        chk("x3_ldat",     ldat_b, 32'hDEAD_BEEF);

        // write to x0 is ignored, during and after the edge
        RegWriteW = 1'b1; RD_W = 5'd0; ResultW = 32'hFFFF_FFFF; A1 = 5'd0;
        #1;
        chk("x0_during_byp", rd1_b, 32'd0);
        chk("x0_during_nob", rd1_n, 32'd0);
        tick();
        RegWriteW = 1'b0;
        #1;
        chk("x0_after_rd1", rd1_b, 32'd0);
        chk("x0_after_cnt", cnt_b, 32'd1);
        chk("x0_after_lrd", {27'd0, lrd_b}, 32'd3);
        chk("x0_after_ldat", ldat_b, 32'hDEAD_BEEF);

        // x7 = 0x11, then same-cycle rewrite with both ports on x7
        RegWriteW = 1'b1; RD_W = 5'd7; ResultW = 32'h0000_0011;
        tick();
        RD_W = 5'd7; ResultW = 32'h0000_0022; A1 = 5'd7; A2 = 5'd7; dbg_addr = 5'd7;
        #1;
        chk("byp_rd1",     rd1_b, 32'h0000_0022);
        chk("byp_rd2",     rd2_b, 32'h0000_0022);
        chk("byp_dbg_old", dbg_b, 32'h0000_0011);
        chk("nob_rd1_old", rd1_n, 32'h0000_0011);
        chk("nob_rd2_old", rd2_n, 32'h0000_0011);
        A2 = 5'd3;
        #1;
        chk("byp_rd2_other", rd2_b, 32'hDEAD_BEEF);
        chk("byp_rd1_still", rd1_b, 32'h0000_0022);
        tick();
        RegWriteW = 1'b0;
        #1;
        chk("nob_rd1_new", rd1_n, 32'h0000_0022);
        chk("byp_dbg_new", dbg_b, 32'h0000_0022);
        chk("x7_cnt",      cnt_b, 32'd3);

        // counter wrap on the bypassing instance
        force u_dut_byp.r_wb_count = 32'hFFFF_FFFF;
        #1;
        release u_dut_byp.r_wb_count;
        #1;
        chk("wrap_preset", cnt_b, 32'hFFFF_FFFF);
        RegWriteW = 1'b1; RD_W = 5'd1; ResultW = 32'h0000_00A5;
        tick();
        RegWriteW = 1'b0;
        #1;
        chk("wrap_cnt",     cnt_b, 32'd0);
        chk("wrap_lrd",     {27'd0, lrd_b}, 32'd1);
        chk("wrap_ldat",    ldat_b, 32'h0000_00A5);
        chk("nowrap_cnt",   cnt_n, 32'd4);

        // write coincident with reset must not land
        rst = 1'b1; RegWriteW = 1'b1; RD_W = 5'd9; ResultW = 32'h0000_CAFE;
        tick();
        RegWriteW = 1'b0; rst = 1'b0; dbg_addr = 5'd9;
        #1;
        chk("race_x9",  dbg_b, 32'd0);
        chk("race_cnt", cnt_b, 32'd0);
        chk("race_nob_cnt", cnt_n, 32'd0);

        // top index after reset released
        RegWriteW = 1'b1; RD_W = 5'd31; ResultW = 32'h8000_0001;
        tick();
        RegWriteW = 1'b0; A1 = 5'd31; dbg_addr = 5'd31;
        #1;
        chk("x31_rd1", rd1_n, 32'h8000_0001);
        chk("x31_dbg", dbg_b, 32'h8000_0001);
        chk("x31_cnt", cnt_b, 32'd1);
        chk("x31_lrd", {27'd0, lrd_b}, 32'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/register_file_wb.md
Name: register_file_wb

Overview:
- Integer register file for the RV32I pipeline; the consuming end of the writeback interface (RegWriteW, RD_W, ResultW).
- Commits results on the clock edge and serves two decode-stage read ports, with optional same-cycle writeback-to-decode bypass.
- Carries a debug read port and writeback bookkeeping (commit counter, last-commit capture) for bench and trace use.

Parameters:
- XLEN, 32, data width of each register and of ResultW
- NREG, 32, number of architectural registers; index 0 is hardwired zero
- AW, 5, register index width; must satisfy 2**AW == NREG
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see only committed state

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- RegWriteW  input  1  writeback write enable
- RD_W  input  AW  writeback destination index
- ResultW  input  XLEN  writeback data, from the writeback result mux
- A1  input  AW  read port 1 index (rs1, decode)
- A2  input  AW  read port 2 index (rs2, decode)
- RD1  output  XLEN  read port 1 data
- RD2  output  XLEN  read port 2 data
- dbg_addr  input  AW  debug read index
- dbg_data  output  XLEN  debug read data; committed state only, never bypassed
- wb_count  output  32  number of committed writes since reset
- last_rd  output  AW  index of most recent committed write
- last_data  output  XLEN  data of most recent committed write

Behaviour:
- Reset: rst high clears every register, wb_count, last_rd and last_data to 0 immediately, regardless of clk. Held while rst is high. Writes are blocked for the whole time rst is high, including on a rising clk edge.
- Commit condition: RegWriteW==1 and RD_W!=0, sampled at the rising clk edge.
- Commit actions: reg[RD_W] <= ResultW; wb_count <= wb_count+1; last_rd <= RD_W; last_data <= ResultW.
- Write to x0 (RegWriteW==1, RD_W==0): fully ignored. No register change, no count, no last_* update.
- wb_count wraps 0xFFFFFFFF -> 0x00000000 with no flag.
- Read ports are combinational, zero latency:
  - If Ax==0: RDx = 0.
  - Else if BYPASS==1, RegWriteW==1 and RD_W==Ax: RDx = ResultW (write-first in the same cycle).
  - Else: RDx = reg[Ax].
- With BYPASS==0, the same-cycle read returns the old value; the new value is visible from the cycle after the edge.
- Both ports may read the same index, with or without bypass; each evaluates independently.
- dbg_data = reg[dbg_addr]; reads 0 for index 0.
- Only one write port exists, so there is no write-write conflict.
- Reset dominates any same-edge write.
- No X propagation: every register holds a defined value from reset onward.

Test Plan:
- Reset then read: assert rst mid-run after x5=0x1234 is written -> RD1 with A1=5 reads 0 immediately, before any clk edge; wb_count=0, last_rd=0, last_data=0.
- Basic commit: RegWriteW=1, RD_W=3, ResultW=0xDEADBEEF, one edge -> next cycle RD2 (A2=3)=0xDEADBEEF, dbg_data (dbg_addr=3)=0xDEADBEEF, wb_count=1, last_rd=3, last_data=0xDEADBEEF.
- x0 protection: RegWriteW=1, RD_W=0, ResultW=0xFFFFFFFF -> RD1 (A1=0)=0 both during and after the edge; wb_count and last_* unchanged.
- Bypass, BYPASS=1: x7 holds 0x11; drive RegWriteW=1, RD_W=7, ResultW=0x22 with A1=A2=7 -> RD1=RD2=0x22 in the same cycle, while dbg_data=0x11 until the edge.
- No bypass, BYPASS=0: same stimulus -> RD1=0x11 before the edge and 0x22 after.
- Counter and reset race: force wb_count to 0xFFFFFFFF via 2^32-1 commits (or a bench force), then one commit -> wb_count=0. Separately, a write coincident with rst high -> target register stays 0.
